simplez_cpu: RTL and testbench



---
 rtl/simplez_cpu.sv | 117 +++++++++++
 tb/tb_simplez_cpu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/simplez_cpu.sv
// Simplez processor core: 12-bit accumulator machine, 8-opcode ISA, FETCH/EXEC cycle.
// Memory handshake is combinational; the memory samples on the falling clock edge.
module simplez_cpu #(
  parameter logic [8:0] PC_INIT = 9'd0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [8:0]  mem_addr,
  output logic        mem_wr,
  output logic [11:0] mem_dout,
  input  logic [11:0] mem_din,
  output logic [11:0] acc,
  output logic [8:0]  pc,
  output logic        zero,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t      state_r, state_next_s;
  logic [8:0]  pc_r, pc_next_s;
  logic [11:0] acc_r, acc_next_s;
  logic [11:0] ir_r, ir_next_s;
  logic [8:0]  mem_addr_s;
  logic        mem_wr_s;
  logic [2:0]  op_s;
  logic [8:0]  cd_s;
  logic        zero_s;

  assign op_s     = ir_r[11:9];
  assign cd_s     = ir_r[8:0];
  assign zero_s   = (acc_r == 12'd0);
  assign mem_addr = mem_addr_s;
  assign mem_wr   = mem_wr_s;
  assign mem_dout = acc_r;
  assign acc      = acc_r;
  assign pc       = pc_r;
  assign zero     = zero_s;
  assign halted   = (state_r == S_HALT);

  // Architectural state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_FETCH;
      pc_r    <= PC_INIT;
      acc_r   <= 12'd0;
      ir_r    <= 12'd0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      acc_r   <= acc_next_s;
      ir_r    <= ir_next_s;
    end
  end

  // Sequencing, memory drive and instruction execution
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    acc_next_s   = acc_r;
    ir_next_s    = ir_r;
    mem_addr_s   = pc_r;
    mem_wr_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_addr_s   = pc_r;
        ir_next_s    = mem_din;
        pc_next_s    = pc_r + 9'd1;
        state_next_s = S_EXEC;
      end
      S_EXEC: begin
        mem_addr_s   = cd_s;
        state_next_s = S_FETCH;
        case (op_s)
          OP_ST:   mem_wr_s   = 1'b1;
          OP_LD:   acc_next_s = mem_din;
          OP_ADD:  acc_next_s = acc_r + mem_din;
          OP_BR:   pc_next_s  = cd_s;
          // Z reflects acc as left by the previous instruction
          OP_BZ: begin
            if (zero_s) begin
              pc_next_s = cd_s;
            end else begin
              pc_next_s = pc_r;
            end
          end
          OP_CLR:  acc_next_s   = 12'd0;
          OP_DEC:  acc_next_s   = acc_r - 12'd1;
          OP_HALT: state_next_s = S_HALT;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_HALT: begin
        mem_addr_s   = pc_r;
        state_next_s = S_HALT;
      end
      default: begin
        mem_addr_s   = pc_r;
        state_next_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_simplez_cpu.sv
// Directed self-checking bench for simplez_cpu with a falling-edge 512x12 memory model.
module tb_simplez_cpu;

  logic        clk;
  logic        rstn;
  logic [8:0]  mem_addr;
  logic        mem_wr;
  logic [11:0] mem_dout;
  logic [11:0] mem_din;
  logic [11:0] acc;
  logic [8:0]  pc;
  logic        zero;
  logic        halted;

  logic [11:0] mem [0:511];
  int n_checks;
  int n_errors;
  int n_writes;

  simplez_cpu #(.PC_INIT(9'd0)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .acc      (acc),
    .pc       (pc),
    .zero     (zero),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: write and read on the falling edge
  always @(negedge clk) begin
    if (mem_wr) begin
      mem[mem_addr] = mem_dout;
      n_writes = n_writes + 1;
    end
    mem_din = mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_program();
    rstn = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 512; i++) mem[i] = 12'd0;
    n_writes = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    start_program();
    mem[0] = 12'o1010; mem[1] = 12'o2011; mem[2] = 12'o0012; mem[3] = 12'o7000;
    mem[8] = 12'd5;    mem[9] = 12'd7;
    release_reset();
    step(2);
    n_checks++; if (acc !== 12'd5) begin n_errors++; $display("FAIL t1_ld acc=%0d exp=5", acc); end
    step(5);
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL t1_halt_early halted=%0b exp=0", halted); end
    step(1);
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL t1_halt halted=%0b exp=1", halted); end
    step(3);
    n_checks++; if (pc !== 9'd4) begin n_errors++; $display("FAIL t1_pc pc=%0d exp=4", pc); end
    n_checks++; if (acc !== 12'd12) begin n_errors++; $display("FAIL t1_acc acc=%0d exp=12", acc); end
    n_checks++; if (mem[10] !== 12'd12) begin n_errors++; $display("FAIL t1_mem10 got=%0d exp=12", mem[10]); end
    n_checks++; if (mem_dout !== 12'd12) begin n_errors++; $display("FAIL t1_dout got=%0d exp=12", mem_dout); end
    n_checks++; if (n_writes !== 1) begin n_errors++; $display("FAIL t1_writes got=%0d exp=1", n_writes); end
    n_checks++; if (mem_addr !== 9'd4) begin n_errors++; $display("FAIL t1_halt_addr got=%0d exp=4", mem_addr); end
  endtask

  task automatic test_reset();
    // CPU is halted with acc=12 from the previous test
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (acc !== 12'd0) begin n_errors++; $display("FAIL rst_acc got=%0d exp=0", acc); end
    n_checks++; if (pc !== 9'd0) begin n_errors++; $display("FAIL rst_pc got=%0d exp=0", pc); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    n_checks++; if (zero !== 1'b1) begin n_errors++; $display("FAIL rst_zero got=%0b exp=1", zero); end
    n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL rst_wr got=%0b exp=0", mem_wr); end
    n_checks++; if (mem_addr !== 9'd0) begin n_errors++; $display("FAIL rst_addr got=%0d exp=0", mem_addr); end
  endtask

  task automatic test_clr_dec();
    start_program();
    mem[0] = 12'o5000; mem[1] = 12'o6000; mem[2] = 12'o7000;
    release_reset();
    step(2);
    n_checks++; if (acc !== 12'd0 || zero !== 1'b1) begin n_errors++; $display("FAIL t2_clr acc=%0d zero=%0b exp 0/1", acc, zero); end
    step(2);
    n_checks++; if (acc !== 12'o7777) begin n_errors++; $display("FAIL t2_dec acc=%o exp=7777", acc); end
    n_checks++; if (zero !== 1'b0) begin n_errors++; $display("FAIL t2_zero got=%0b exp=0", zero); end
    step(2);
    n_checks++; if (halted !== 1'b1 || pc !== 9'd3) begin n_errors++; $display("FAIL t2_halt halted=%0b pc=%0d exp 1/3", halted, pc); end
    n_checks++; if (n_writes !== 0) begin n_errors++; $display("FAIL t2_writes got=%0d exp=0", n_writes); end
  endtask

  task automatic test_bz();
    start_program();
    mem[0] = 12'o5000; mem[1] = 12'o4024; mem[20] = 12'o7000;
    release_reset();
    step(4);
    n_checks++; if (pc !== 9'd20) begin n_errors++; $display("FAIL t3_bz_taken pc=%0d exp=20", pc); end
    step(4);
    n_checks++; if (halted !== 1'b1 || pc !== 9'd21) begin n_errors++; $display("FAIL t3_taken_halt halted=%0b pc=%0d exp 1/21", halted, pc); end

    start_program();
    mem[0] = 12'o6000; mem[1] = 12'o4024; mem[2] = 12'o7000;
    release_reset();
    step(4);
    n_checks++; if (pc !== 9'd2) begin n_errors++; $display("FAIL t3_bz_not_taken pc=%0d exp=2", pc); end
    step(2);
    n_checks++; if (halted !== 1'b1 || pc !== 9'd3) begin n_errors++; $display("FAIL t3_nt_halt halted=%0b pc=%0d exp 1/3", halted, pc); end
  endtask

  task automatic test_add_overflow();
    start_program();
    mem[0] = 12'o6000; mem[1] = 12'o2005; mem[2] = 12'o7000; mem[5] = 12'd1;
    release_reset();
    step(2);
    n_checks++; if (acc !== 12'o7777) begin n_errors++; $display("FAIL t4_dec acc=%o exp=7777", acc); end
    step(2);
    n_checks++; if (acc !== 12'd0 || zero !== 1'b1) begin n_errors++; $display("FAIL t4_add acc=%0d zero=%0b exp 0/1", acc, zero); end
  endtask

  task automatic test_pc_wrap();
    start_program();
    mem[0] = 12'o3777; mem[511] = 12'o5000;
    release_reset();
    step(2);
    n_checks++; if (pc !== 9'd511) begin n_errors++; $display("FAIL t5_br pc=%0d exp=511", pc); end
    step(1);
    n_checks++; if (pc !== 9'd0) begin n_errors++; $display("FAIL t5_wrap pc=%0d exp=0", pc); end
    step(1);
    n_checks++; if (mem_addr !== 9'd0) begin n_errors++; $display("FAIL t5_fetch_addr got=%0d exp=0", mem_addr); end
  endtask

  task automatic test_reset_mid_st();
    start_program();
    mem[0] = 12'o6000; mem[1] = 12'o0024; mem[2] = 12'o7000; mem[20] = 12'o1234;
    release_reset();
    step(3);
    n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 9'd20) begin n_errors++; $display("FAIL t6_st_exec wr=%0b addr=%0d exp 1/20", mem_wr, mem_addr); end
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL t6_wr_drop got=%0b exp=0", mem_wr); end
    n_checks++; if (pc !== 9'd0 || acc !== 12'd0) begin n_errors++; $display("FAIL t6_regs pc=%0d acc=%0d exp 0/0", pc, acc); end
    @(negedge clk); #1;
    n_checks++; if (mem[20] !== 12'o1234) begin n_errors++; $display("FAIL t6_target got=%o exp=1234", mem[20]); end
    n_checks++; if (n_writes !== 0) begin n_errors++; $display("FAIL t6_writes got=%0d exp=0", n_writes); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_writes = 0;
    mem_din  = 12'd0;
    rstn     = 1'b0;
    test_basic();
    test_reset();
    test_clr_dec();
    test_bz();
    test_add_overflow();
    test_pc_wrap();
    test_reset_mid_st();
    chk("final_idle_wr", {31'd0, mem_wr}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
